multicycle_ctrl_fsm: RTL and testbench

- Main control sequencer for the multi-cycle RISC-V datapath variant (RV32I subset: lw, sw, R-ALU, I-ALU, beq, jal).
- Walks each instruction through fetch/decode/execute/memory/writeback states and drives every datapath select, including ImmSrc for the immediate extender.
- Stalls on a memory-ready handshake and traps on unsupported opcodes.

---
 rtl/multicycle_ctrl_fsm_pkg.sv | 56 +++++
 rtl/multicycle_ctrl_fsm_alu_decoder.sv | 39 +++
 rtl/multicycle_ctrl_fsm.sv | 168 ++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle RV32I control sequencer:
// state encoding, opcode constants, ImmSrc codes, ALUOp and ALUControl codes.
package multicycle_ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecuteR,
    StExecuteI,
    StAluWb,
    StJal,
    StBeq,
    StTrap
  } state_e;

  // Opcodes of the supported RV32I subset
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  // Immediate extender formats
  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  // ALUOp: coarse operation class handed to the ALU decoder
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  // ALUControl codes
  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  // Immediate format depends only on the opcode, never on the state
  function automatic logic [1:0] imm_src_for(input logic [6:0] op);
    unique case (op)
      OpStore:  return ImmS;
      OpBranch: return ImmB;
      OpJal:    return ImmJ;
      default:  return ImmI;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_alu_decoder.sv
// ALU decoder: maps ALUOp plus instruction fields to an ALUControl code.
// Purely combinational.
module alu_decoder
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int unsigned ALUCTRL_W = 3
) (
  input  logic [1:0]           alu_op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 op5,
  output logic [ALUCTRL_W-1:0] alu_control
);

  logic [2:0] code;

  // Decode operation class, then funct3 for ALU-type instructions
  always_comb begin
    code = AluAdd;
    unique case (alu_op)
      AluOpAdd: code = AluAdd;
      AluOpSub: code = AluSub;
      AluOpFunct: begin
        case (funct3)
          // Only R-type (op[5]=1) can encode sub; addi ignores bit 30
          3'b000:  code = (funct7b5 && op5) ? AluSub : AluAdd;
          3'b010:  code = AluSlt;
          3'b110:  code = AluOr;
          3'b111:  code = AluAnd;
          default: code = AluAdd;
        endcase
      end
      default: code = AluAdd;
    endcase
  end

  assign alu_control = ALUCTRL_W'(code);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control sequencer for the multi-cycle RV32I datapath.
// Walks each instruction through fetch/decode/execute/memory/writeback,
// stalls on mem_ready and traps on unsupported opcodes.
// Optional macro BRANCH_BNE_EN: adds bne (funct3=001) to the branch state.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int unsigned ALUCTRL_W       = 3,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic                 RegWrite,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 illegal_instr
);

  state_e     state, next_state;
  logic [1:0] alu_op;
  logic       pc_write, mem_write, ir_write, reg_write;
  logic       branch_take;

  // Next-state selection
  always_comb begin
    next_state = state;
    case (state)
      StFetch: next_state = mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (op)
          OpLoad, OpStore: next_state = StMemAdr;
          OpRType:         next_state = StExecuteR;
          OpIType:         next_state = StExecuteI;
          OpJal:           next_state = StJal;
          OpBranch:        next_state = StBeq;
          default:         next_state = TRAP_ON_ILLEGAL ? StTrap : StFetch;
        endcase
      end
      StMemAdr:   next_state = op[5] ? StMemWrite : StMemRead;
      StMemRead:  next_state = mem_ready ? StMemWb : StMemRead;
      StMemWb:    next_state = StFetch;
      StMemWrite: next_state = mem_ready ? StFetch : StMemWrite;
      StExecuteR: next_state = StAluWb;
      StExecuteI: next_state = StAluWb;
      StAluWb:    next_state = StFetch;
      StJal:      next_state = StAluWb;
      StBeq:      next_state = StFetch;
      StTrap:     next_state = StTrap;
      default:    next_state = StFetch;
    endcase
  end

  // State register and sticky trap flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= StFetch;
      illegal_instr <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == StTrap) begin
        illegal_instr <= 1'b1;
      end
    end
  end

  // Branch condition evaluated in the BEQ state
  always_comb begin
`ifdef BRANCH_BNE_EN
    case (funct3)
      3'b000:  branch_take = zero;
      3'b001:  branch_take = ~zero;
      default: branch_take = 1'b0;
    endcase
`else
    branch_take = zero;
`endif
  end

  // Datapath selects and raw enables decoded from the current state
  always_comb begin
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = AluOpAdd;
    pc_write  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    case (state)
      StFetch: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      StMemRead: AdrSrc = 1'b1;
      StMemWb: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      StMemWrite: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      StExecuteR: begin
        ALUSrcA = 2'b10;
        alu_op  = AluOpFunct;
      end
      StExecuteI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = AluOpFunct;
      end
      StAluWb: reg_write = 1'b1;
      StJal: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pc_write = 1'b1;
      end
      StBeq: begin
        ALUSrcA  = 2'b10;
        alu_op   = AluOpSub;
        pc_write = branch_take;
      end
      default: ;
    endcase
  end

  // Enables are forced low for as long as reset is held
  assign PCWrite  = pc_write & rst_n;
  assign MemWrite = mem_write & rst_n;
  assign IRWrite  = ir_write & rst_n;
  assign RegWrite = reg_write & rst_n;

  assign ImmSrc = imm_src_for(op);

  alu_decoder #(
    .ALUCTRL_W(ALUCTRL_W)
  ) u_alu_decoder (
    .alu_op     (alu_op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alu_control(ALUControl)
  );

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed testbench for multicycle_ctrl_fsm.
module tb_multicycle_ctrl_fsm;
  import multicycle_ctrl_fsm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  int n_checks = 0;
  int n_fail = 0;

  multicycle_ctrl_fsm #(
    .ALUCTRL_W      (3),
    .TRAP_ON_ILLEGAL(1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .op           (op),
    .funct3       (funct3),
    .funct7b5     (funct7b5),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .PCWrite      (PCWrite),
    .AdrSrc       (AdrSrc),
    .MemWrite     (MemWrite),
    .IRWrite      (IRWrite),
    .ResultSrc    (ResultSrc),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .RegWrite     (RegWrite),
    .ImmSrc       (ImmSrc),
    .ALUControl   (ALUControl),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string tag, input state_e exp);
    check_eq(tag, 32'(dut.state), 32'(exp));
  endtask

  // Advance one clock; sampling point is 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // R-type or I-type ALU instruction, mem_ready held high: 4 cycles
  task automatic run_alu(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input logic [2:0] exp_ctl);
    op = opc; funct3 = f3; funct7b5 = f7; mem_ready = 1'b1; zero = 1'b0;
    #1;
    chk_state("alu_fetch", StFetch);
    check_eq("alu_fetch_irwrite", IRWrite, 1'b1);
    check_eq("alu_fetch_regwrite", RegWrite, 1'b0);
    tick();
    chk_state("alu_decode", StDecode);
    check_eq("alu_decode_ctl", ALUControl, AluAdd);
    check_eq("alu_decode_regwrite", RegWrite, 1'b0);
    tick();
    chk_state("alu_exec", opc[5] ? StExecuteR : StExecuteI);
    check_eq("alu_exec_ctl", ALUControl, exp_ctl);
    check_eq("alu_exec_srca", ALUSrcA, 2'b10);
    check_eq("alu_exec_srcb", ALUSrcB, opc[5] ? 2'b00 : 2'b01);
    check_eq("alu_exec_regwrite", RegWrite, 1'b0);
    tick();
    chk_state("alu_wb", StAluWb);
    check_eq("alu_wb_regwrite", RegWrite, 1'b1);
    check_eq("alu_wb_result", ResultSrc, 2'b00);
    tick();
    chk_state("alu_done", StFetch);
  endtask

  // Branch: 3 cycles, PCWrite in the branch state decides the outcome
  task automatic run_branch(input logic [2:0] f3, input logic z, input logic exp_pc);
    op = OpBranch; funct3 = f3; zero = z; mem_ready = 1'b1;
    #1;
    tick();
    chk_state("br_decode", StDecode);
    tick();
    chk_state("br_state", StBeq);
    check_eq("br_pcwrite", PCWrite, exp_pc);
    check_eq("br_ctl", ALUControl, AluSub);
    check_eq("br_imm", ImmSrc, ImmB);
    check_eq("br_srca", ALUSrcA, 2'b10);
    check_eq("br_regwrite", RegWrite, 1'b0);
    tick();
    chk_state("br_done", StFetch);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    // Reset: FETCH, enables off even with mem_ready high, FETCH selects
    chk_state("rst_state", StFetch);
    check_eq("rst_pcwrite", PCWrite, 1'b0);
    check_eq("rst_irwrite", IRWrite, 1'b0);
    check_eq("rst_memwrite", MemWrite, 1'b0);
    check_eq("rst_regwrite", RegWrite, 1'b0);
    check_eq("rst_illegal", illegal_instr, 1'b0);
    check_eq("rst_srcb", ALUSrcB, 2'b10);
    check_eq("rst_result", ResultSrc, 2'b10);
    check_eq("rst_adrsrc", AdrSrc, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fetch stall: no enables while memory is not ready
    mem_ready = 1'b0; op = OpRType;
    #1;
    check_eq("fstall_irwrite", IRWrite, 1'b0);
    check_eq("fstall_pcwrite", PCWrite, 1'b0);
    tick();
    chk_state("fstall_hold", StFetch);

    // ALU instructions: add, sub, slt, or, and, other funct3, addi with bit30 set
    run_alu(OpRType, 3'b000, 1'b0, AluAdd);
    run_alu(OpRType, 3'b000, 1'b1, AluSub);
    run_alu(OpRType, 3'b010, 1'b0, AluSlt);
    run_alu(OpRType, 3'b110, 1'b0, AluOr);
    run_alu(OpRType, 3'b111, 1'b0, AluAnd);
    run_alu(OpRType, 3'b001, 1'b0, AluAdd);
    run_alu(OpIType, 3'b000, 1'b1, AluAdd);

    // lw with two not-ready cycles in MEMREAD: 7 cycles total
    op = OpLoad; funct3 = 3'b010; funct7b5 = 1'b0; mem_ready = 1'b1;
    #1;
    tick();
    tick();
    chk_state("lw_memadr", StMemAdr);
    check_eq("lw_memadr_srca", ALUSrcA, 2'b10);
    check_eq("lw_memadr_srcb", ALUSrcB, 2'b01);
    check_eq("lw_imm", ImmSrc, ImmI);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_ready = 1'b1;
      #1;
      chk_state("lw_memread", StMemRead);
      check_eq("lw_memread_adrsrc", AdrSrc, 1'b1);
      check_eq("lw_memread_regwrite", RegWrite, 1'b0);
      tick();
    end
    chk_state("lw_memwb", StMemWb);
    check_eq("lw_memwb_regwrite", RegWrite, 1'b1);
    check_eq("lw_memwb_result", ResultSrc, 2'b01);
    tick();
    chk_state("lw_done", StFetch);

    // beq taken and not taken; funct3=001 depends on the bne option
    run_branch(3'b000, 1'b1, 1'b1);
    run_branch(3'b000, 1'b0, 1'b0);
`ifdef BRANCH_BNE_EN
    run_branch(3'b001, 1'b0, 1'b1);
    run_branch(3'b001, 1'b1, 1'b0);
`else
    run_branch(3'b001, 1'b0, 1'b0);
    run_branch(3'b001, 1'b1, 1'b1);
`endif

    // jal: 4 cycles, PCWrite in JAL, RegWrite in ALUWB
    op = OpJal; zero = 1'b0; mem_ready = 1'b1;
    #1;
    tick();
    tick();
    chk_state("jal_state", StJal);
    check_eq("jal_pcwrite", PCWrite, 1'b1);
    check_eq("jal_srca", ALUSrcA, 2'b01);
    check_eq("jal_srcb", ALUSrcB, 2'b10);
    check_eq("jal_imm", ImmSrc, ImmJ);
    check_eq("jal_regwrite", RegWrite, 1'b0);
    tick();
    chk_state("jal_wb", StAluWb);
    check_eq("jal_wb_regwrite", RegWrite, 1'b1);
    tick();
    chk_state("jal_done", StFetch);

    // sw with three not-ready cycles: MemWrite held for 4 cycles
    op = OpStore; funct3 = 3'b010; mem_ready = 1'b1;
    #1;
    tick();
    tick();
    chk_state("sw_memadr", StMemAdr);
    check_eq("sw_imm", ImmSrc, ImmS);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      #1;
      chk_state("sw_memwrite", StMemWrite);
      check_eq("sw_memwrite_strobe", MemWrite, 1'b1);
      check_eq("sw_adrsrc", AdrSrc, 1'b1);
      tick();
    end
    chk_state("sw_done", StFetch);
    check_eq("sw_done_memwrite", MemWrite, 1'b0);

    // Reset during a stalled store: strobe drops at once, back to FETCH
    mem_ready = 1'b1;
    #1;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    #1;
    check_eq("rstmw_before", MemWrite, 1'b1);
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check_eq("rstmw_memwrite", MemWrite, 1'b0);
    check_eq("rstmw_irwrite", IRWrite, 1'b0);
    chk_state("rstmw_state", StFetch);
    tick();
    rst_n = 1'b1;
    #1;
    chk_state("rstmw_release", StFetch);
    check_eq("rstmw_release_memwrite", MemWrite, 1'b0);
    tick();
    chk_state("rstmw_next", StDecode);
    tick();
    tick();
    chk_state("rstmw_resume", StMemWrite);
    tick();

    // Illegal opcode: TRAP after DECODE, sticky flag, no enables
    op = 7'b1111111; mem_ready = 1'b1; zero = 1'b1;
    #1;
    chk_state("trap_fetch", StFetch);
    tick();
    chk_state("trap_decode", StDecode);
    check_eq("trap_decode_flag", illegal_instr, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk_state("trap_state", StTrap);
      check_eq("trap_flag", illegal_instr, 1'b1);
      check_eq("trap_pcwrite", PCWrite, 1'b0);
      check_eq("trap_irwrite", IRWrite, 1'b0);
      check_eq("trap_regwrite", RegWrite, 1'b0);
      check_eq("trap_memwrite", MemWrite, 1'b0);
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk_state("trap_rst_state", StFetch);
    check_eq("trap_rst_flag", illegal_instr, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    chk_state("trap_release", StFetch);
    check_eq("trap_release_flag", illegal_instr, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
